// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the generic pipeline stage register:
//   default bundle widths per stage boundary, control-bundle field
//   offsets, per-boundary bubble constants (all write enables low) and
//   the occupancy encoding used by pipe_stage_elastic.
//   No ports (package).
package pipe_pkg;

  // Default bundle widths per stage boundary.
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_CTRL_W   = 16;
  localparam int IFID_DATA_W  = 64;  // PC + instruction word
  localparam int IFID_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 32;
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 32;
  localparam int EXMEM_CTRL_W = 16;
  localparam int MEMWB_DATA_W = 32;
  localparam int MEMWB_CTRL_W = 16;

  // Control-bundle field layout (LSB offsets and widths).
  localparam int CTRL_ALUOP_LSB     = 0;
  localparam int CTRL_ALUOP_W       = 4;
  localparam int CTRL_D_MEM_BE_LSB  = 4;
  localparam int CTRL_D_MEM_BE_W    = 4;
  localparam int CTRL_D_MEM_WEN_BIT = 8;
  localparam int CTRL_RWSRC_LSB     = 9;
  localparam int CTRL_RWSRC_W       = 2;
  localparam int CTRL_RF_WE_BIT     = 11;
  localparam int CTRL_HALT_BIT      = 12;

  // Bubble constants: every write enable and HALT deasserted.
  localparam logic [15:0] IFID_BUBBLE  = 16'h0000;
  localparam logic [15:0] IDEX_BUBBLE  = 16'h0000;
  localparam logic [15:0] EXMEM_BUBBLE = 16'h0000;
  localparam logic [15:0] MEMWB_BUBBLE = 16'h0000;

  // Number of entries held by the stage.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Occupancy from the two slot valids. S is only ever valid while M is.
  function automatic occ_e occ_of(input logic vld_m, input logic vld_s);
    occ_e occ;
    case ({vld_m, vld_s})
      2'b11:   occ = OCC_TWO;
      2'b10:   occ = OCC_ONE;
      2'b01:   occ = OCC_ONE;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
//   One valid + data + control register with load/clear enables.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     load             capture d_data/d_ctrl and set valid (wins over clr)
//     clr              drop the valid bit, data/ctrl keep their value
//     d_data, d_ctrl   next entry
//     vld, data, ctrl  held entry
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = DEF_DATA_W,
  parameter int                 CTRL_W     = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              vld_d, vld_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = d_data;
      ctrl_d = d_ctrl;
    end else if (clr) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ctrl_q <= CTRL_RESET;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign vld  = vld_q;
  assign data = data_q;
  assign ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Generic pipeline stage register with valid/ready handshake, stall
//   back-pressure, synchronous flush, control bubble insertion and an
//   optional 2-entry skid buffer (SKID=1) that makes in_ready a register
//   output.
//
//   Handshake: a transfer happens on an edge where valid and ready are both
//   1 (in: in_valid & in_ready, out: out_valid & out_ready). in_ready never
//   depends on in_valid; with SKID=0 it depends on out_ready, with SKID=1 it
//   is a flop output only. flush beats every transfer: entries held or
//   accepted at a flush edge are dropped.
//
//   Ports:
//     CLK, RSTn                     clock, asynchronous active-low reset
//     flush                         kill held and incoming entries
//     in_valid/in_ready/in_data/in_ctrl     upstream side
//     out_valid/out_ready/out_data/out_ctrl downstream side
//     occupancy                     held entries (0..2)
//     bubble_cnt                    saturating count of out_ready & ~out_valid
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                CTRL_W      = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                SKID        = 0,
  parameter int                CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              vld_m, vld_s;
  logic [DATA_W-1:0] data_m;
  logic [CTRL_W-1:0] ctrl_m;
  logic              m_load, m_clr;
  logic [DATA_W-1:0] m_din_data;
  logic [CTRL_W-1:0] m_din_ctrl;
  logic              accept;

  assign accept = in_valid & in_ready;

  // M always holds the oldest entry and drives the outputs.
  pipe_slot #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .CTRL_RESET (CTRL_BUBBLE)
  ) u_slot_m (
    .clk    (CLK),
    .rst_n  (RSTn),
    .load   (m_load),
    .clr    (m_clr),
    .d_data (m_din_data),
    .d_ctrl (m_din_ctrl),
    .vld    (vld_m),
    .data   (data_m),
    .ctrl   (ctrl_m)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] data_s;
      logic [CTRL_W-1:0] ctrl_s;
      logic              s_load, s_clr;

      pipe_slot #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CTRL_RESET (CTRL_BUBBLE)
      ) u_slot_s (
        .clk    (CLK),
        .rst_n  (RSTn),
        .load   (s_load),
        .clr    (s_clr),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .vld    (vld_s),
        .data   (data_s),
        .ctrl   (ctrl_s)
      );

      // Ready only depends on whether the skid slot is free.
      assign in_ready = ~vld_s;

      // ONE + accept + stall: the new entry parks in S behind M.
      assign s_load = ~flush & accept & vld_m & ~out_ready;
      // TWO + out_ready: S moves into M and frees up.
      assign s_clr  = flush | (vld_s & out_ready);

      // M refills from S when S is occupied, otherwise from the input
      // whenever M is empty or being emitted this cycle.
      assign m_load = ~flush & ((vld_s & out_ready) |
                                (accept & (~vld_m | out_ready)));
      assign m_clr  = flush | (vld_m & out_ready & ~vld_s & ~accept);

      assign m_din_data = vld_s ? data_s : in_data;
      assign m_din_ctrl = vld_s ? ctrl_s : in_ctrl;
    end else begin : g_noskid
      assign vld_s      = 1'b0;
      assign in_ready   = ~vld_m | out_ready;
      assign m_load     = ~flush & accept;
      assign m_clr      = flush | (vld_m & out_ready & ~accept);
      assign m_din_data = in_data;
      assign m_din_ctrl = in_ctrl;
    end
  endgenerate

  assign out_valid = vld_m;
  assign out_data  = data_m;
  assign out_ctrl  = vld_m ? ctrl_m : CTRL_BUBBLE;
  assign occupancy = occ_of(vld_m, vld_s);

  // Bubble performance counter, saturating, cleared only by reset.
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (out_ready && !vld_m && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic
//   Directed bench for pipe_stage_elastic. Two instances share clock and
//   reset: dut0 (SKID=0, CNT_W=4, bubble 16'h0000) and dut1 (SKID=1,
//   CNT_W=16, bubble 16'hBEEF). Inputs change 1 time unit after the rising
//   edge, outputs are checked before the next rising edge.
module tb_pipe_stage_elastic;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [CW-1:0] BUB0 = 16'h0000;
  localparam logic [CW-1:0] BUB1 = 16'hBEEF;

  logic clk;
  logic rst_n;

  // dut0 signals
  logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [DW-1:0] in_data0, out_data0;
  logic [CW-1:0] in_ctrl0, out_ctrl0;
  logic [1:0]    occ0;
  logic [3:0]    cnt0;

  // dut1 signals
  logic          flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [DW-1:0] in_data1, out_data1;
  logic [CW-1:0] in_ctrl1, out_ctrl1;
  logic [1:0]    occ1;
  logic [15:0]   cnt1;

  int n_checks;
  int n_pass;

  pipe_stage_elastic #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB0), .SKID(0), .CNT_W(4)
  ) dut0 (
    .CLK(clk), .RSTn(rst_n), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_ctrl(in_ctrl0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occ0), .bubble_cnt(cnt0)
  );

  pipe_stage_elastic #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB1), .SKID(1), .CNT_W(16)
  ) dut1 (
    .CLK(clk), .RSTn(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_ctrl(in_ctrl1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_ctrl(out_ctrl1),
    .occupancy(occ1), .bubble_cnt(cnt1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic v, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic r, input logic f);
    in_valid0 = v; in_data0 = d; in_ctrl0 = c; out_ready0 = r; flush0 = f;
  endtask

  task automatic drive1(input logic v, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic r, input logic f);
    in_valid1 = v; in_data1 = d; in_ctrl1 = c; out_ready1 = r; flush1 = f;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive0(1'b0, '0, '0, 1'b0, 1'b0);
    drive1(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL rst0_valid got %b exp 0", out_valid0); else n_pass++;
    n_checks++; if (out_ctrl0 !== BUB0) $display("FAIL rst0_ctrl got %h exp %h", out_ctrl0, BUB0); else n_pass++;
    n_checks++; if (out_data0 !== '0) $display("FAIL rst0_data got %h exp 0", out_data0); else n_pass++;
    n_checks++; if (occ0 !== 2'd0) $display("FAIL rst0_occ got %0d exp 0", occ0); else n_pass++;
    n_checks++; if (in_ready0 !== 1'b1) $display("FAIL rst0_in_ready got %b exp 1", in_ready0); else n_pass++;
    n_checks++; if (out_ctrl1 !== BUB1) $display("FAIL rst1_ctrl got %h exp %h", out_ctrl1, BUB1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b1) $display("FAIL rst1_in_ready got %b exp 1", in_ready1); else n_pass++;
    n_checks++; if (cnt1 !== 16'd0) $display("FAIL rst1_cnt got %0d exp 0", cnt1); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream_noskid();
    drive0(1'b1, 32'h1000, 16'h0011, 1'b0, 1'b0);
    tick();
    drive0(1'b1, 32'h1004, 16'h0022, 1'b1, 1'b0);
    #1;
    n_checks++; if (out_data0 !== 32'h1000) $display("FAIL stream0_d0 got %h exp 1000", out_data0); else n_pass++;
    n_checks++; if (out_ctrl0 !== 16'h0011) $display("FAIL stream0_c0 got %h exp 0011", out_ctrl0); else n_pass++;
    n_checks++; if (in_ready0 !== 1'b1) $display("FAIL stream0_rdy got %b exp 1", in_ready0); else n_pass++;
    tick();
    drive0(1'b1, 32'h1008, 16'h0033, 1'b1, 1'b0);
    n_checks++; if (out_data0 !== 32'h1004) $display("FAIL stream0_d1 got %h exp 1004", out_data0); else n_pass++;
    n_checks++; if (out_valid0 !== 1'b1) $display("FAIL stream0_v1 got %b exp 1", out_valid0); else n_pass++;
    tick();
    drive0(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (out_data0 !== 32'h1008) $display("FAIL stream0_d2 got %h exp 1008", out_data0); else n_pass++;
    n_checks++; if (out_valid0 !== 1'b1) $display("FAIL stream0_v2 got %b exp 1", out_valid0); else n_pass++;
    n_checks++; if (cnt0 !== 4'd0) $display("FAIL stream0_cnt got %0d exp 0", cnt0); else n_pass++;
    tick();
    drive0(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL stream0_drain got %b exp 0", out_valid0); else n_pass++;
    n_checks++; if (out_ctrl0 !== BUB0) $display("FAIL stream0_bub got %h exp %h", out_ctrl0, BUB0); else n_pass++;
    n_checks++; if (out_data0 !== 32'h1008) $display("FAIL stream0_hold got %h exp 1008", out_data0); else n_pass++;
    n_checks++; if (occ0 !== 2'd0) $display("FAIL stream0_occ got %0d exp 0", occ0); else n_pass++;
  endtask

  task automatic test_comb_ready();
    drive0(1'b1, 32'h55, 16'h0055, 1'b0, 1'b0);
    tick();
    in_valid0 = 1'b0;
    out_ready0 = 1'b1; #1;
    n_checks++; if (in_ready0 !== 1'b1) $display("FAIL cready_a got %b exp 1", in_ready0); else n_pass++;
    out_ready0 = 1'b0; #1;
    n_checks++; if (in_ready0 !== 1'b0) $display("FAIL cready_b got %b exp 0", in_ready0); else n_pass++;
    n_checks++; if (occ0 !== 2'd1) $display("FAIL cready_occ got %0d exp 1", occ0); else n_pass++;
    out_ready0 = 1'b1; #1;
    n_checks++; if (in_ready0 !== 1'b1) $display("FAIL cready_c got %b exp 1", in_ready0); else n_pass++;
    n_checks++; if (out_ctrl0 !== 16'h0055) $display("FAIL cready_ctrl got %h exp 0055", out_ctrl0); else n_pass++;
    tick();
    out_ready0 = 1'b0;
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL cready_emit got %b exp 0", out_valid0); else n_pass++;
    n_checks++; if (in_ready0 !== 1'b1) $display("FAIL cready_empty got %b exp 1", in_ready0); else n_pass++;
  endtask

  task automatic test_counter_sat();
    n_checks++; if (cnt0 !== 4'd0) $display("FAIL sat_start got %0d exp 0", cnt0); else n_pass++;
    drive0(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (14) tick();
    n_checks++; if (cnt0 !== 4'd14) $display("FAIL sat_14 got %0d exp 14", cnt0); else n_pass++;
    repeat (6) tick();
    n_checks++; if (cnt0 !== 4'd15) $display("FAIL sat_20 got %0d exp 15", cnt0); else n_pass++;
    tick();
    n_checks++; if (cnt0 !== 4'd15) $display("FAIL sat_hold got %0d exp 15", cnt0); else n_pass++;
    out_ready0 = 1'b0;
  endtask

  task automatic test_skid_stall();
    drive1(1'b1, 32'h10, 16'h0101, 1'b0, 1'b0);
    tick();
    drive1(1'b1, 32'h20, 16'h0202, 1'b0, 1'b0);
    n_checks++; if (occ1 !== 2'd1) $display("FAIL skid_occ1 got %0d exp 1", occ1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b1) $display("FAIL skid_rdy1 got %b exp 1", in_ready1); else n_pass++;
    tick();
    // Offer an entry that must be refused while full.
    drive1(1'b1, 32'h99, 16'h0909, 1'b0, 1'b0);
    n_checks++; if (occ1 !== 2'd2) $display("FAIL skid_occ2 got %0d exp 2", occ1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b0) $display("FAIL skid_rdy2 got %b exp 0", in_ready1); else n_pass++;
    n_checks++; if (out_data1 !== 32'h10) $display("FAIL skid_head got %h exp 10", out_data1); else n_pass++;
    tick();
    drive1(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (occ1 !== 2'd2) $display("FAIL skid_hold2 got %0d exp 2", occ1); else n_pass++;
    n_checks++; if (out_data1 !== 32'h10) $display("FAIL skid_out0 got %h exp 10", out_data1); else n_pass++;
    n_checks++; if (out_ctrl1 !== 16'h0101) $display("FAIL skid_ctl0 got %h exp 0101", out_ctrl1); else n_pass++;
    tick();
    n_checks++; if (out_data1 !== 32'h20) $display("FAIL skid_out1 got %h exp 20", out_data1); else n_pass++;
    n_checks++; if (out_ctrl1 !== 16'h0202) $display("FAIL skid_ctl1 got %h exp 0202", out_ctrl1); else n_pass++;
    n_checks++; if (occ1 !== 2'd1) $display("FAIL skid_occ_after got %0d exp 1", occ1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b1) $display("FAIL skid_rdy_after got %b exp 1", in_ready1); else n_pass++;
    tick();
    out_ready1 = 1'b0;
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL skid_empty got %b exp 0", out_valid1); else n_pass++;
    n_checks++; if (out_ctrl1 !== BUB1) $display("FAIL skid_bub got %h exp %h", out_ctrl1, BUB1); else n_pass++;
    n_checks++; if (cnt1 !== 16'd0) $display("FAIL skid_cnt got %0d exp 0", cnt1); else n_pass++;
  endtask

  task automatic test_skid_stream();
    drive1(1'b1, 32'h70, 16'h0707, 1'b0, 1'b0);
    tick();
    drive1(1'b1, 32'h74, 16'h0747, 1'b1, 1'b0);
    n_checks++; if (out_data1 !== 32'h70) $display("FAIL sstream_d0 got %h exp 70", out_data1); else n_pass++;
    tick();
    drive1(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (out_data1 !== 32'h74) $display("FAIL sstream_d1 got %h exp 74", out_data1); else n_pass++;
    n_checks++; if (occ1 !== 2'd1) $display("FAIL sstream_occ got %0d exp 1", occ1); else n_pass++;
    tick();
    out_ready1 = 1'b0;
    n_checks++; if (occ1 !== 2'd0) $display("FAIL sstream_empty got %0d exp 0", occ1); else n_pass++;
  endtask

  task automatic test_flush();
    logic [15:0] cnt_base;
    cnt_base = cnt1;
    drive1(1'b1, 32'h40, 16'h0404, 1'b0, 1'b0);
    tick();
    drive1(1'b1, 32'h50, 16'h0505, 1'b0, 1'b0);
    tick();
    n_checks++; if (occ1 !== 2'd2) $display("FAIL flush_full got %0d exp 2", occ1); else n_pass++;
    drive1(1'b1, 32'h30, 16'h0303, 1'b0, 1'b1);
    tick();
    drive1(1'b1, 32'h60, 16'h0606, 1'b0, 1'b0);
    n_checks++; if (occ1 !== 2'd0) $display("FAIL flush_occ got %0d exp 0", occ1); else n_pass++;
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL flush_valid got %b exp 0", out_valid1); else n_pass++;
    n_checks++; if (out_ctrl1 !== BUB1) $display("FAIL flush_ctrl got %h exp %h", out_ctrl1, BUB1); else n_pass++;
    n_checks++; if (out_data1 !== 32'h40) $display("FAIL flush_data got %h exp 40", out_data1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b1) $display("FAIL flush_rdy got %b exp 1", in_ready1); else n_pass++;
    tick();
    // Flush while an accept completes: the accepted entry must vanish.
    n_checks++; if (out_data1 !== 32'h60) $display("FAIL flush_one got %h exp 60", out_data1); else n_pass++;
    drive1(1'b1, 32'h30, 16'h0303, 1'b0, 1'b1);
    tick();
    drive1(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (occ1 !== 2'd0) $display("FAIL flush_acc_occ got %0d exp 0", occ1); else n_pass++;
    n_checks++; if (out_data1 !== 32'h60) $display("FAIL flush_acc_data got %h exp 60", out_data1); else n_pass++;
    tick();
    tick();
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL flush_no_c got %b exp 0", out_valid1); else n_pass++;
    n_checks++; if (cnt1 !== cnt_base + 16'd2) $display("FAIL flush_cnt got %0d exp %0d", cnt1, cnt_base + 16'd2); else n_pass++;
    out_ready1 = 1'b0;
  endtask

  task automatic test_reset_midrun();
    drive0(1'b1, 32'hABCD, 16'h00FF, 1'b0, 1'b0);
    drive1(1'b1, 32'h1234, 16'h0F0F, 1'b0, 1'b0);
    tick();
    drive0(1'b0, '0, '0, 1'b0, 1'b0);
    drive1(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (out_valid0 !== 1'b1) $display("FAIL mid_pre0 got %b exp 1", out_valid0); else n_pass++;
    n_checks++; if (out_valid1 !== 1'b1) $display("FAIL mid_pre1 got %b exp 1", out_valid1); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL mid0_valid got %b exp 0", out_valid0); else n_pass++;
    n_checks++; if (out_ctrl0 !== BUB0) $display("FAIL mid0_ctrl got %h exp %h", out_ctrl0, BUB0); else n_pass++;
    n_checks++; if (out_data0 !== '0) $display("FAIL mid0_data got %h exp 0", out_data0); else n_pass++;
    n_checks++; if (occ0 !== 2'd0) $display("FAIL mid0_occ got %0d exp 0", occ0); else n_pass++;
    n_checks++; if (in_ready0 !== 1'b1) $display("FAIL mid0_rdy got %b exp 1", in_ready0); else n_pass++;
    n_checks++; if (cnt0 !== 4'd0) $display("FAIL mid0_cnt got %0d exp 0", cnt0); else n_pass++;
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL mid1_valid got %b exp 0", out_valid1); else n_pass++;
    n_checks++; if (out_ctrl1 !== BUB1) $display("FAIL mid1_ctrl got %h exp %h", out_ctrl1, BUB1); else n_pass++;
    n_checks++; if (out_data1 !== '0) $display("FAIL mid1_data got %h exp 0", out_data1); else n_pass++;
    n_checks++; if (cnt1 !== 16'd0) $display("FAIL mid1_cnt got %0d exp 0", cnt1); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (occ1 !== 2'd0) $display("FAIL mid1_after got %0d exp 0", occ1); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_stream_noskid();
    test_comb_ready();
    test_counter_sat();
    test_skid_stall();
    test_skid_stream();
    test_flush();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed ID/EX latch: one generic pipeline stage register carrying a data bundle and a control bundle between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, stall back-pressure and synchronous flush.
- Forces a programmable control "bubble" whenever the stage is empty or flushed.
- Provides an optional 2-entry skid buffer so that the ready path is fully registered.

Parameters:
DATA_W, 32, width of datapath bundle (PC, operands, immediate, ...)
CTRL_W, 16, width of control bundle (ALUOp, mem enables, RF_WE, ...)
CTRL_BUBBLE, 0, value driven on out_ctrl when the stage holds no valid entry (must deassert all write enables)
SKID, 0, 0 = single register with combinational ready; 1 = main register plus skid register, registered in_ready
CNT_W, 16, width of the bubble performance counter

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  reset, asynchronous, active-low
flush  input  1  synchronous kill of all held and incoming entries
in_valid  input  1  upstream entry present
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream datapath bundle
in_ctrl  input  CTRL_W  upstream control bundle
out_valid  output  1  held entry valid
out_ready  input  1  downstream accepts (0 = stall)
out_data  output  DATA_W  held datapath bundle
out_ctrl  output  CTRL_W  held control, or CTRL_BUBBLE when not valid
occupancy  output  2  number of held entries (0..1 when SKID=0, 0..2 when SKID=1)
bubble_cnt  output  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0

Behaviour:
Decided: one clock CLK; reset RSTn is asynchronous and active-low.

Reset:
- Values while RSTn=0: vld_m=vld_s=0, data regs=0, ctrl regs=CTRL_BUBBLE, bubble_cnt=0.
- Resulting outputs: out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, occupancy=0.
- in_ready=1 when SKID=0, and also when SKID=1 (vld_s=0).

Transfer rules:
- Accept = in_valid & in_ready.
- Emit = out_valid & out_ready.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle) when the stage is empty.
- out_ctrl = vld_m ? ctrl_m : CTRL_BUBBLE (combinational mux on the register output).
- out_data holds its last value when invalid. Do not zero it; it carries no side effects.

SKID=0:
- in_ready = ~vld_m | out_ready (combinational).
- On Accept, M loads in_*; vld_m=1.
- On Emit without Accept, vld_m=0.
- Accept and Emit in the same cycle: M reloads and vld_m stays 1 (full throughput).

SKID=1:
- in_ready = ~vld_s (a register output, no combinational in-to-out path).
- States by occupancy:
  - EMPTY (0): Accept -> ONE.
  - ONE (1):
    - Accept & ~out_ready: input goes to S -> TWO.
    - Accept & out_ready: M reloads, stays ONE.
    - ~Accept & out_ready -> EMPTY.
  - TWO (2):
    - out_ready: M<=S, vld_s=0 -> ONE.
    - in_ready=0, so no Accept is possible.
- Ordering is strictly FIFO: M always holds the oldest entry.

Flush:
- flush=1 at an edge clears vld_m and vld_s, and discards any Accept in that cycle.
- Result next cycle: occupancy=0, out_ctrl=CTRL_BUBBLE.
- Flush has priority over Accept, Emit and stall.
- in_ready is not gated by flush; upstream may see its handshake complete, but the entry is dropped.
- Data regs are left unchanged.

bubble_cnt:
- Increments when out_ready & ~out_valid, including flush-induced bubbles.
- Saturates at 2^CNT_W-1.
- Cleared only by reset.

Reset mid-operation: asynchronous reset drops all entries immediately. No partial state survives.

Decomposition:
- Shared package pipe_pkg:
  - CTRL_W and DATA_W defaults per stage boundary.
  - Control-bundle field offsets (ALUOp, D_MEM_BE, D_MEM_WEN, RWSrc, RF_WE, HALT, ...).
  - Per-stage CTRL_BUBBLE constants (IDEX_BUBBLE, EXMEM_BUBBLE, ...).
- One sub-module, pipe_slot: a single valid+data+ctrl register with load/clear enables. It is instantiated once for M and, under generate when SKID=1, once for S.
- Handshake, occupancy and counter logic live in the top module.

Test Plan:
- Reset/idle: RSTn=0 mid-run with CTRL_BUBBLE=16'h0000 -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1, immediately and without waiting for a clock edge.
- Streaming, SKID=0: in_valid=1 every cycle with in_data=0x1000,0x1004,0x1008, out_ready=1 -> out_data shows the same sequence one cycle later, out_valid=1 continuous, bubble_cnt unchanged.
- Stall with skid, SKID=1: fill with A=0x10 then B=0x20 while out_ready=0 -> occupancy=2, in_ready=0. Raise out_ready -> out_data=0x10, then 0x20, then out_valid=0; no entry is lost or duplicated.
- Flush: occupancy=2 plus in_valid=1 with C=0x30 and flush=1 for one edge -> next cycle occupancy=0, out_ctrl=CTRL_BUBBLE, and C never appears on out_data.
- Combinational ready, SKID=0: vld_m=1, out_ready toggling 1,0,1 -> in_ready follows 1,0,1 in the same cycle.
- Counter saturation: CNT_W=4, 20 cycles of out_ready=1 with an empty stage -> bubble_cnt=15, held at 15.
